// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous memory between instruction fetch (I) and load/store (D).
// D has priority; a streak counter forces a pending fetch through after MAX_D_STREAK D grants.
module mem_port_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned STREAK_W     = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_mask,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_mask,
  input  logic [31:0] mem_rdata,
  output logic [31:0] perf_conflicts
);

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_I    = 2'd1,
    RESP_D    = 2'd2
  } resp_t;

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  logic [STREAK_W-1:0] streak;
  logic [STREAK_W-1:0] streakNext;
  resp_t               respSel;
  resp_t               respNext;
  logic                forceI;
  logic                unusedAddrLsbs;

  // Word-aligned port: the byte offset never reaches the memory.
  assign unusedAddrLsbs = ^{i_addr[1:0], d_addr[1:0]};

  assign forceI = (MAX_D_STREAK != 0) && (streak == STREAK_MAX) && i_req;
  assign d_gnt  = rst_n && d_req && !forceI;
  assign i_gnt  = rst_n && i_req && !d_gnt;

  // Memory port drive for the single granted requester.
  always_comb begin
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_mask  = 4'd0;
    if (d_gnt) begin
      mem_addr = {d_addr[31:2], 2'b00};
      if (d_we) begin
        mem_wen   = 1'b1;
        mem_wdata = d_wdata;
        mem_mask  = d_mask;
      end else begin
        mem_ren = 1'b1;
      end
    end else if (i_gnt) begin
      mem_ren  = 1'b1;
      mem_addr = {i_addr[31:2], 2'b00};
    end
  end

  // Next streak and response tag.
  always_comb begin
    streakNext = streak;
    respNext   = RESP_NONE;
    if (i_gnt || !i_req) begin
      streakNext = '0;
    end else if (d_gnt) begin
      streakNext = (streak == STREAK_MAX) ? streak : streak + STREAK_W'(1);
    end
    if (i_gnt) begin
      respNext = RESP_I;
    end else if (d_gnt && !d_we) begin
      respNext = RESP_D;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      streak         <= '0;
      respSel        <= RESP_NONE;
      perf_conflicts <= 32'd0;
    end else begin
      streak  <= streakNext;
      respSel <= respNext;
      if (i_req && d_req) begin
        perf_conflicts <= perf_conflicts + 32'd1;
      end
    end
  end

  // Read data is shared; only the tagged requester sees rvalid.
  assign i_rvalid = (respSel == RESP_I);
  assign d_rvalid = (respSel == RESP_D);
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a driver checks grants and memory drive each cycle and
// queues expected read responses; a monitor pops and checks them when rvalid appears.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_mask;
  logic [31:0] memRdata = 32'd0;

  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_ren, mem_wen;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, perf_conflicts;
  logic [3:0]  mem_mask;

  logic        iGnt1, iRvalid1, dGnt1, dRvalid1, memRen1, memWen1;
  logic [31:0] iRdata1, dRdata1, memAddr1, memWdata1, perf1;
  logic [3:0]  memMask1;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_D_STREAK(4), .STREAK_W(3)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_mask(d_mask),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mask(mem_mask), .mem_rdata(memRdata), .perf_conflicts(perf_conflicts)
  );

  mem_port_arbiter #(.MAX_D_STREAK(0), .STREAK_W(3)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(iGnt1), .i_rvalid(iRvalid1), .i_rdata(iRdata1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_mask(d_mask),
    .d_gnt(dGnt1), .d_rvalid(dRvalid1), .d_rdata(dRdata1),
    .mem_ren(memRen1), .mem_wen(memWen1), .mem_addr(memAddr1), .mem_wdata(memWdata1),
    .mem_mask(memMask1), .mem_rdata(memRdata), .perf_conflicts(perf1)
  );

  // Behavioural memory behind dut0: write at the edge, read data one cycle later.
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] rdMem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'hDEADBEEF;
  endfunction

  always @(posedge clk) begin
    logic [31:0] w;
    if (mem_wen) begin
      w = rdMem(mem_addr);
      for (int b = 0; b < 4; b++) begin
        if (mem_mask[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
      end
      mem[mem_addr] = w;
    end
    if (mem_ren) memRdata <= rdMem(mem_addr);
  end

  int cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  typedef struct {
    bit          isD;
    logic [31:0] data;
    int          cyc;
  } resp_exp_t;

  resp_exp_t sbq[$];
  int nChecks = 0;
  int nFail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycleCnt);
    end
  endtask

  // Monitor: every rvalid must match the oldest queued expectation, one cycle after its grant.
  always @(negedge clk) begin
    resp_exp_t e;
    if (i_rvalid || d_rvalid) begin
      if (i_rvalid && d_rvalid) begin
        chk("both_rvalid", 32'(i_rvalid & d_rvalid), 32'd0);
      end else if (sbq.size() == 0) begin
        chk("unexpected_rvalid", 32'({i_rvalid, d_rvalid}), 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("resp_side_d", 32'(d_rvalid), 32'(e.isD));
        chk("resp_latency", 32'(cycleCnt - e.cyc), 32'd1);
        chk("resp_data", e.isD ? d_rdata : i_rdata, e.data);
      end
    end else if (sbq.size() > 0 && sbq[0].cyc < cycleCnt) begin
      e = sbq.pop_front();
      chk("missing_rvalid", 32'd0, 32'd1);
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Checks grants and memory drive at the current sample point and queues any read response.
  task automatic expectCycle(input logic eI, input logic eD, input logic eRen, input logic eWen,
                             input logic [31:0] eAddr, input logic [31:0] eWdata,
                             input logic [3:0] eMask, input bit pushResp, input bit rIsD,
                             input logic [31:0] rData);
    chk("i_gnt", 32'(i_gnt), 32'(eI));
    chk("d_gnt", 32'(d_gnt), 32'(eD));
    chk("mem_ren", 32'(mem_ren), 32'(eRen));
    chk("mem_wen", 32'(mem_wen), 32'(eWen));
    chk("mem_addr", mem_addr, eAddr);
    chk("mem_wdata", mem_wdata, eWdata);
    chk("mem_mask", 32'(mem_mask), 32'(eMask));
    if (pushResp) sbq.push_back('{isD: rIsD, data: rData, cyc: cycleCnt});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    mem[32'h0000_0104] = 32'h0104_CAFE;
    mem[32'h0000_2000] = 32'h1122_3344;
    mem[32'h0000_3000] = 32'h3333_0000;
    mem[32'h0000_4000] = 32'h4444_0000;

    // Reset held with both requesting: no grants, no enables.
    rst_n = 1'b0; i_req = 1'b1; i_addr = 32'h104; d_req = 1'b1; d_we = 1'b0;
    d_addr = 32'h3000; d_wdata = 32'd0; d_mask = 4'd0;
    repeat (2) nextCycle();
    @(negedge clk);
    expectCycle(0, 0, 0, 0, 32'd0, 32'd0, 4'd0, 0, 0, 32'd0);
    chk("rst_dut1_d_gnt", 32'(dGnt1), 32'd0);
    nextCycle();

    rst_n = 1'b1; i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("post_rst_i_rvalid", 32'(i_rvalid), 32'd0);
    chk("post_rst_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("post_rst_perf", perf_conflicts, 32'd0);
    expectCycle(0, 0, 0, 0, 32'd0, 32'd0, 4'd0, 0, 0, 32'd0);
    nextCycle();

    // Instruction fetch alone; the last address has nonzero byte offset.
    for (int k = 0; k < 3; k++) begin
      i_req = 1'b1; i_addr = (k == 2) ? 32'h107 : 32'h104;
      @(negedge clk);
      expectCycle(1, 0, 1, 0, 32'h104, 32'd0, 4'd0, 1, 0, 32'h0104_CAFE);
      nextCycle();
    end

    // Byte write to lane 2 of 0x2000, then read back.
    i_req = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2002;
    d_mask = 4'b0100; d_wdata = 32'h00AB_0000;
    @(negedge clk);
    expectCycle(0, 1, 0, 1, 32'h2000, 32'h00AB_0000, 4'b0100, 0, 0, 32'd0);
    nextCycle();

    d_we = 1'b0; d_addr = 32'h2000; d_mask = 4'hF; d_wdata = 32'd0;
    @(negedge clk);
    expectCycle(0, 1, 1, 0, 32'h2000, 32'd0, 4'd0, 1, 1, 32'h11AB_3344);
    nextCycle();

    d_req = 1'b0; d_wdata = 32'h5555_5555;
    @(negedge clk);
    expectCycle(0, 0, 0, 0, 32'd0, 32'd0, 4'd0, 0, 0, 32'd0);
    nextCycle();

    // Continuous conflict: D,D,D,D,I on dut0; strict D priority on dut1.
    i_req = 1'b1; i_addr = 32'h104; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
    d_wdata = 32'd0; d_mask = 4'd0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("perf_conflicts", perf_conflicts, 32'(j));
      chk("streak", 32'(dut0.streak), 32'(j % 5));
      chk("nofair_d_gnt", 32'(dGnt1), 32'd1);
      chk("nofair_i_gnt", 32'(iGnt1), 32'd0);
      if (j % 5 == 4)
        expectCycle(1, 0, 1, 0, 32'h104, 32'd0, 4'd0, 1, 0, 32'h0104_CAFE);
      else
        expectCycle(0, 1, 1, 0, 32'h3000, 32'd0, 4'd0, 1, 1, 32'h3333_0000);
      nextCycle();
    end

    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("perf_after_conflict", perf_conflicts, 32'd10);
    chk("streak_after_i", 32'(dut0.streak), 32'd0);
    expectCycle(0, 0, 0, 0, 32'd0, 32'd0, 4'd0, 0, 0, 32'd0);
    nextCycle();

    // D read granted, then reset lands on the following edge: response is dropped.
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000;
    @(negedge clk);
    expectCycle(0, 1, 1, 0, 32'h4000, 32'd0, 4'd0, 0, 0, 32'd0);
    #1;
    rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0;
    nextCycle();
    @(negedge clk);
    chk("rst_mid_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rst_mid_i_rvalid", 32'(i_rvalid), 32'd0);
    chk("rst_mid_streak", 32'(dut0.streak), 32'd0);
    chk("rst_mid_perf", perf_conflicts, 32'd0);
    nextCycle();

    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rel_perf", perf_conflicts, 32'd0);
    expectCycle(0, 0, 0, 0, 32'd0, 32'd0, 4'd0, 0, 0, 32'd0);
    nextCycle();

    // Fetch still works after reset.
    i_req = 1'b1; i_addr = 32'h104;
    @(negedge clk);
    expectCycle(1, 0, 1, 0, 32'h104, 32'd0, 4'd0, 1, 0, 32'h0104_CAFE);
    nextCycle();
    i_req = 1'b0;
    repeat (3) nextCycle();
    @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one synchronous memory port (read data returned one cycle after the request edge; byte-masked writes) between the instruction-fetch requester (I) and the load/store requester (D).
- Sits between the pipeline's IF/MEM stages and a unified single-port memory.
- Grant is combinational, the read response is returned with a one-cycle tag, and a starvation counter guarantees forward progress for fetch.

Parameters:
- MAX_D_STREAK, 4, consecutive D grants allowed while I is pending before I is forced through; 0 disables fairness (strict D priority).
- STREAK_W, 3, width of the streak counter; must hold MAX_D_STREAK.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk
- i_req  in  1  instruction read request
- i_addr  in  32  instruction byte address
- i_gnt  out  1  I request accepted this cycle (combinational)
- i_rvalid  out  1  i_rdata valid (registered, one cycle after i_gnt)
- i_rdata  out  32  instruction word
- d_req  in  1  data request
- d_we  in  1  1 = write, 0 = read
- d_addr  in  32  data byte address
- d_wdata  in  32  write data
- d_mask  in  4  byte-enable mask; bit k covers bits [8k+7:8k]
- d_gnt  out  1  D request accepted this cycle (combinational)
- d_rvalid  out  1  d_rdata valid (reads only, one cycle after d_gnt)
- d_rdata  out  32  loaded word
- mem_ren  out  1  memory read enable
- mem_wen  out  1  memory write enable
- mem_addr  out  32  granted address with bits [1:0] forced to 0
- mem_wdata  out  32  write data
- mem_mask  out  4  byte mask; d_mask on a write, 4'b0000 otherwise
- mem_rdata  in  32  memory read data, valid one cycle after mem_ren
- perf_conflicts  out  32  count of cycles with i_req and d_req both high

Behaviour:
- Only one requester is granted per cycle.
  - force_i = (MAX_D_STREAK != 0) && (streak == MAX_D_STREAK) && i_req.
  - d_gnt = rst_n && d_req && !force_i.
  - i_gnt = rst_n && i_req && !d_gnt.
- Memory drive:
  - D read: mem_ren=1.
  - D write: mem_wen=1, mem_mask=d_mask, mem_wdata=d_wdata.
  - I grant: mem_ren=1.
  - No grant: mem_ren=mem_wen=0, mem_addr=0, mem_wdata=0, mem_mask=0.
  - mem_ren and mem_wen are never both high.
- Streak counter (reg, STREAK_W bits):
  - d_gnt && i_req: increment, saturating at MAX_D_STREAK.
  - i_gnt or !i_req: clear to 0.
  - Otherwise: hold.
- Response tag resp_sel (NONE/I/D), registered each posedge:
  - I if i_gnt.
  - D if d_gnt && !d_we.
  - NONE otherwise.
- Response outputs:
  - i_rvalid = (resp_sel==I); d_rvalid = (resp_sel==D).
  - i_rdata = d_rdata = mem_rdata; the non-selected requester ignores its copy.
  - Data is valid for exactly one cycle. The requester must capture it; there is no hold or backpressure.
- Writes complete at the grant edge and produce no rvalid. Read-after-write to the same word on the next cycle returns the new data, because the memory orders the write before the subsequent read.
- Back-to-back grants are allowed every cycle (throughput 1 access/cycle). A response and a new grant coexist in the same cycle.
- perf_conflicts increments when i_req && d_req && rst_n, and wraps from 0xFFFFFFFF to 0.
- Reset (rst_n=0 at posedge):
  - streak=0, resp_sel=NONE, perf_conflicts=0.
  - While rst_n=0, gnts and mem enables are 0.
  - Cycle after reset: i_rvalid=d_rvalid=0, including when a read was granted in the cycle before reset; that response is dropped.
- Address bits [1:0] are ignored for word selection; no misalignment error is raised.

Test Plan:
- Reset: hold rst_n=0 with i_req=d_req=1 -> i_gnt=d_gnt=0, mem_ren=mem_wen=0; first cycle after release shows rvalids=0 and perf_conflicts=0.
- I only: i_req=1, i_addr=0x104 for 3 cycles -> i_gnt=1 and mem_addr=0x104 each cycle; i_rvalid=1 in cycles 2-4 with i_rdata=mem_rdata.
- D write then read: d_we=1, d_addr=0x2002, d_mask=4'b0100, d_wdata=0x00AB0000 -> mem_wen=1, mem_addr=0x2000, no d_rvalid. Then d read of 0x2000 -> d_rvalid=1 one cycle later, byte 2 = 0xAB, other bytes unchanged.
- Conflict, MAX_D_STREAK=4: both request continuously -> grant pattern D,D,D,D,I repeating; perf_conflicts increments every cycle; streak returns to 0 after each I grant.
- Fairness disabled, MAX_D_STREAK=0: both request for 10 cycles -> d_gnt all 10 cycles, i_gnt never asserted.
- Reset mid-read: grant D read, assert rst_n=0 on the next posedge -> d_rvalid stays 0; streak=0 and perf_conflicts=0 after reset.
